// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared constants and helpers for the SRAM round-robin arbiter
package sram_arb_pkg;

  // Request op encodings, chosen to match the SRAM WEN pin sense
  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  // Geometry of the SRAM instance this arbiter normally fronts
  localparam int DEF_WIDTH     = 128;
  localparam int DEF_ADD_WIDTH = 11;

  // Ceiling log2, used to size index/pointer fields (clog2(1) = 0)
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_rr_arbiter_core.sv
// rtl/sram_rr_arbiter_core.sv - combinational round-robin grant search (rr_arb_core)
module rr_arb_core
  import sram_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any_gnt
);

  int idx;

  // Walk ptr, ptr+1, ... (mod N) and grant the first asserted request
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      // The modulo keeps the index legal even if ptr were ever out of range
      idx = (int'(ptr) + k) % N;
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - round-robin sharing of one single-port SRAM; SRAM_ARB_RSP_REG_EN adds a response register stage
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADD_WIDTH = DEF_ADD_WIDTH,
  parameter int PTR_W     = 2
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_wen,
  input  logic [NUM_REQ*ADD_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [WIDTH-1:0]             rsp_data,
  output logic                         sram_cen,
  output logic                         sram_wen,
  output logic [ADD_WIDTH-1:0]         sram_a,
  output logic [WIDTH-1:0]             sram_d,
  input  logic [WIDTH-1:0]             sram_q
);

  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               any_gnt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic               rd_pend;
  logic [PTR_W-1:0]   rd_id;
  logic               rd_issue;
  logic [NUM_REQ-1:0] rsp_valid_c;

  rr_arb_core #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_core (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // The grant itself is the ready; it never looks at op, address or data
  assign req_ready = gnt;

  // Steer the granted requester onto the SRAM pins; idle pins park deselected and zero
  always_comb begin
    sram_cen = 1'b1;
    sram_wen = OP_READ;
    sram_a   = '0;
    sram_d   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sram_cen = 1'b0;
        sram_wen = req_wen[i];
        sram_a   = req_addr[i*ADD_WIDTH +: ADD_WIDTH];
        sram_d   = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next search start is one past the winner, wrapping at NUM_REQ
  always_comb begin
    if (int'(gnt_idx) >= NUM_REQ - 1) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = gnt_idx + 1'b1;
    end
  end

  // Pointer advances only on a grant so idle cycles keep fairness state
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= ptr_nxt;
    end
  end

  assign rd_issue = any_gnt && (sram_wen == OP_READ);

  // Remember who issued a read so the SRAM's next-cycle Q can be strobed to them
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_id   <= '0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) begin
        rd_id <= gnt_idx;
      end
    end
  end

  // Decode the pending read owner into a one-hot strobe; reset kills it at once
  always_comb begin
    rsp_valid_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_c[i] = rd_pend && (int'(rd_id) == i);
    end
  end

`ifdef SRAM_ARB_RSP_REG_EN
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;

  // Extra retiming stage on the response; data only moves when a strobe passes through
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_c;
      if (|rsp_valid_c) begin
        rsp_data_q <= sram_q;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`else
  // SRAM Q is already registered inside the macro, so pass it straight through
  assign rsp_valid = rsp_valid_c;
  assign rsp_data  = sram_q;
`endif

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb/tb_sram_rr_arbiter.sv - table-driven check of sram_rr_arbiter against a behavioural SRAM
module tb_sram_rr_arbiter;

  localparam int NR = 3;
  localparam int W  = 16;
  localparam int AW = 8;
  localparam int PW = 2;
`ifdef SRAM_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NROWS = 30;

  logic             CLK;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_wen;
  logic [NR*AW-1:0] req_addr;
  logic [NR*W-1:0]  req_data;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [W-1:0]     rsp_data;
  logic             sram_cen;
  logic             sram_wen;
  logic [AW-1:0]    sram_a;
  logic [W-1:0]     sram_d;
  logic [W-1:0]     sram_q;

  logic [W-1:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  v;
    logic [2:0]  w;
    logic [23:0] a;
    logic [47:0] d;
    logic [2:0]  er;
    logic [2:0]  erv;
    logic [15:0] erd;
  } row_t;

  row_t tab [NROWS];

  sram_rr_arbiter #(
    .NUM_REQ   (NR),
    .WIDTH     (W),
    .ADD_WIDTH (AW),
    .PTR_W     (PW)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .req_valid (req_valid),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single-port SRAM: write on WEN=0, registered read address on WEN=1
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      else           sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic row_t mk(input logic [2:0] v, input logic [2:0] w,
                              input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                              input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                              input logic [2:0] er, input logic [2:0] erv, input logic [15:0] erd);
    row_t r;
    r.v = v; r.w = w; r.a = {a2, a1, a0}; r.d = {d2, d1, d0};
    r.er = er; r.erv = erv; r.erd = erd;
    return r;
  endfunction

  function automatic row_t idle(input logic [2:0] erv, input logic [15:0] erd);
    return mk(3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 16'h0, 16'h0, 16'h0, 3'b000, erv, erd);
  endfunction

  task automatic drive(input logic [2:0] v, input logic [2:0] w, input logic [23:0] a, input logic [47:0] d);
    req_valid = v;
    req_wen   = w;
    req_addr  = a;
    req_data  = d;
  endtask

  initial begin
    logic [2:0]  exp_rv;
    logic [15:0] exp_rd;
    logic        exp_cen, exp_wen;
    logic [7:0]  exp_a;
    logic [15:0] exp_d;

    // Rsp columns give the response expected in that row for a 1-cycle read latency
    tab[0]  = idle(3'b000, 16'h0);
    tab[1]  = mk(3'b001, 3'b000, 8'd5, 8'd0, 8'd0, 16'hA5A5, 16'h0, 16'h0, 3'b001, 3'b000, 16'h0);
    tab[2]  = idle(3'b000, 16'h0);
    tab[3]  = mk(3'b001, 3'b001, 8'd5, 8'd0, 8'd0, 16'h0, 16'h0, 16'h0, 3'b001, 3'b000, 16'h0);
    tab[4]  = idle(3'b001, 16'hA5A5);
    tab[5]  = mk(3'b010, 3'b000, 8'd0, 8'd20, 8'd0, 16'h0, 16'h2020, 16'h0, 3'b010, 3'b000, 16'h0);
    tab[6]  = mk(3'b100, 3'b000, 8'd0, 8'd0, 8'd30, 16'h0, 16'h0, 16'h3030, 3'b100, 3'b000, 16'h0);
    tab[7]  = mk(3'b001, 3'b000, 8'd10, 8'd0, 8'd0, 16'h1010, 16'h0, 16'h0, 3'b001, 3'b000, 16'h0);
    tab[8]  = mk(3'b010, 3'b000, 8'd0, 8'd7, 8'd0, 16'h0, 16'h0011, 16'h0, 3'b010, 3'b000, 16'h0);
    tab[9]  = mk(3'b100, 3'b000, 8'd0, 8'd0, 8'd40, 16'h0, 16'h0, 16'h4040, 3'b100, 3'b000, 16'h0);
    tab[10] = mk(3'b111, 3'b111, 8'd10, 8'd20, 8'd30, 16'h0, 16'h0, 16'h0, 3'b001, 3'b000, 16'h0);
    tab[11] = mk(3'b111, 3'b111, 8'd10, 8'd20, 8'd30, 16'h0, 16'h0, 16'h0, 3'b010, 3'b001, 16'h1010);
    tab[12] = mk(3'b111, 3'b111, 8'd10, 8'd20, 8'd30, 16'h0, 16'h0, 16'h0, 3'b100, 3'b010, 16'h2020);
    tab[13] = mk(3'b111, 3'b111, 8'd10, 8'd20, 8'd30, 16'h0, 16'h0, 16'h0, 3'b001, 3'b100, 16'h3030);
    tab[14] = mk(3'b111, 3'b111, 8'd10, 8'd20, 8'd30, 16'h0, 16'h0, 16'h0, 3'b010, 3'b001, 16'h1010);
    tab[15] = mk(3'b111, 3'b111, 8'd10, 8'd20, 8'd30, 16'h0, 16'h0, 16'h0, 3'b100, 3'b010, 16'h2020);
    tab[16] = mk(3'b010, 3'b010, 8'd0, 8'd20, 8'd0, 16'h0, 16'h0, 16'h0, 3'b010, 3'b100, 16'h3030);
    tab[17] = mk(3'b001, 3'b001, 8'd10, 8'd0, 8'd0, 16'h0, 16'h0, 16'h0, 3'b001, 3'b010, 16'h2020);
    tab[18] = mk(3'b101, 3'b101, 8'd10, 8'd0, 8'd30, 16'h0, 16'h0, 16'h0, 3'b100, 3'b001, 16'h1010);
    tab[19] = mk(3'b001, 3'b001, 8'd7, 8'd0, 8'd0, 16'h0, 16'h0, 16'h0, 3'b001, 3'b100, 16'h3030);
    tab[20] = mk(3'b010, 3'b000, 8'd0, 8'd7, 8'd0, 16'h0, 16'h0022, 16'h0, 3'b010, 3'b001, 16'h0011);
    tab[21] = mk(3'b100, 3'b100, 8'd0, 8'd0, 8'd7, 16'h0, 16'h0, 16'h0, 3'b100, 3'b000, 16'h0);
    tab[22] = idle(3'b100, 16'h0022);
    tab[23] = idle(3'b000, 16'h0);
    tab[24] = idle(3'b000, 16'h0);
    tab[25] = idle(3'b000, 16'h0);
    tab[26] = idle(3'b000, 16'h0);
    tab[27] = mk(3'b111, 3'b111, 8'd10, 8'd20, 8'd30, 16'h0, 16'h0, 16'h0, 3'b001, 3'b000, 16'h0);
    tab[28] = idle(3'b001, 16'h1010);
    tab[29] = idle(3'b000, 16'h0);

    reset = 1'b1;
    drive(3'b000, 3'b000, 24'h0, 48'h0);
    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset req_ready", 64'(req_ready), 64'h0);
    chk("reset sram_cen", 64'(sram_cen), 64'h1);
    repeat (2) @(posedge CLK);
    #2 reset = 1'b0;

    for (int k = 0; k < NROWS; k++) begin
      @(posedge CLK);
      #2 drive(tab[k].v, tab[k].w, tab[k].a, tab[k].d);
      #1;
      exp_cen = 1'b1; exp_wen = 1'b1; exp_a = 8'h0; exp_d = 16'h0;
      for (int j = 0; j < NR; j++) begin
        if (tab[k].er[j]) begin
          exp_cen = 1'b0;
          exp_wen = tab[k].w[j];
          exp_a   = tab[k].a[j*8 +: 8];
          exp_d   = tab[k].d[j*16 +: 16];
        end
      end
      if (LAT == 1) begin
        exp_rv = tab[k].erv; exp_rd = tab[k].erd;
      end else if (k == 0) begin
        exp_rv = 3'b000; exp_rd = 16'h0;
      end else begin
        exp_rv = tab[k-1].erv; exp_rd = tab[k-1].erd;
      end
      chk($sformatf("row%0d req_ready", k), 64'(req_ready), 64'(tab[k].er));
      chk($sformatf("row%0d sram_cen", k), 64'(sram_cen), 64'(exp_cen));
      chk($sformatf("row%0d sram_wen", k), 64'(sram_wen), 64'(exp_wen));
      chk($sformatf("row%0d sram_a", k), 64'(sram_a), 64'(exp_a));
      chk($sformatf("row%0d sram_d", k), 64'(sram_d), 64'(exp_d));
      chk($sformatf("row%0d rsp_valid", k), 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv != 3'b000)
        chk($sformatf("row%0d rsp_data", k), 64'(rsp_data), 64'(exp_rd));
    end

    // Reset arriving mid-read: read by requester 0 moves ptr to 1
    @(posedge CLK);
    #2 drive(3'b001, 3'b001, {8'd0, 8'd0, 8'd10}, 48'h0);
    #1 chk("rst seq read grant", 64'(req_ready), 64'h1);
    @(posedge CLK);
    #2 drive(3'b111, 3'b111, {8'd30, 8'd20, 8'd10}, 48'h0);
    #1;
    chk("rst seq pre rsp_valid", 64'(rsp_valid), (LAT == 1) ? 64'h1 : 64'h0);
    chk("rst seq pre ready ptr1", 64'(req_ready), 64'h2);
    reset = 1'b1;
    #1;
    chk("rst async rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst ready ptr0", 64'(req_ready), 64'h1);
    chk("rst sram_a", 64'(sram_a), 64'd10);
    @(posedge CLK);
    #2 drive(3'b000, 3'b000, 24'h0, 48'h0);
    reset = 1'b0;
    #1 chk("rst release rsp_valid", 64'(rsp_valid), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #3 chk($sformatf("post rst cyc%0d rsp_valid", k), 64'(rsp_valid), 64'h0);
    end
    @(posedge CLK);
    #2 drive(3'b111, 3'b111, {8'd30, 8'd20, 8'd10}, 48'h0);
    #1 chk("post rst first grant", 64'(req_ready), 64'h1);
    for (int k = 0; k < LAT; k++) begin
      @(posedge CLK);
      #2 drive(3'b000, 3'b000, 24'h0, 48'h0);
    end
    #1;
    chk("post rst rsp_valid", 64'(rsp_valid), 64'h1);
    chk("post rst rsp_data", 64'(rsp_data), 64'h1010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
